split2_sync: RTL and testbench
==============================

Name: split2_sync

Overview:
- Clocked steering split for 4-phase bundled-data channels; the inverse of the two-input merge.
- Accepts one input channel (request, ack, data plus a select bit) and forwards each token to exactly one of two output channels.
- Sits where a merged asynchronous stream must be routed back out to two consumers, bridging into the single-clock domain.

Parameters:
- N, 1, data width of d_i, d0_o, d1_o.
- CW, 8, width of the per-output transfer counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (rst=0 resets).
- r_i  input  1  input channel request.
- a_i  output  1  input channel acknowledge.
- d_i  input  N  input data, bundled with r_i.
- s_i  input  1  select, bundled with r_i; 0 steers to output 0, 1 steers to output 1.
- r0_o  output  1  output 0 request.
- a0_o  input  1  output 0 acknowledge.
- d0_o  output  N  output 0 data.
- r1_o  output  1  output 1 request.
- a1_o  input  1  output 1 acknowledge.
- d1_o  output  N  output 1 data.
- busy  output  1  high whenever the FSM is not in IDLE.
- cnt0  output  CW  completed transfers on output 0.
- cnt1  output  CW  completed transfers on output 1.

Behaviour:
- Reset values: a_i=0, r0_o=0, r1_o=0, d0_o=0, d1_o=0, busy=0, cnt0=0, cnt1=0, FSM=IDLE, synchronizer flops=0. Reset asserted mid-transfer aborts immediately.
- Signal naming: rq = r_i as seen by the FSM; aq0/aq1 = a0_o/a1_o as seen by the FSM (see Optional Feature).
- IDLE: on rq=1, register d_i into d_q and s_i into sel_q, then go to LOAD.
- LOAD: one cycle with no request asserted. d_q drives both d0_o and d1_o, so data is stable at least one cycle before the request rises. Next state is REQ, and r{sel_q}_o is set to 1.
- REQ: hold r{sel}_o=1. On aq{sel}=1: clear r{sel}_o, set a_i=1, increment cnt{sel}, go to RTZ.
- RTZ: wait for rq=0 and aq{sel}=0 together. Then clear a_i and go to IDLE.
- Throughput: at most one token per handshake. Latency from rq seen to r_o rising is 2 cycles.
- The unselected output's ack is ignored in every state.
- An ack arriving in IDLE or LOAD is ignored. It is not an error.
- d_i and s_i are sampled only on the IDLE to LOAD transition. Changes afterwards have no effect.
- d0_o and d1_o hold d_q until the next capture.
- Counters wrap modulo 2^CW. 2^CW−1 followed by one transfer gives 0.
- rq remaining high after RTZ exits is impossible by construction, because RTZ requires rq=0.
- Output requests are one-hot or zero at all times. r0_o and r1_o are never both 1.

Optional Feature:
- Macro: SPLIT2_SYNC_EN.
- Defined: r_i, a0_o and a1_o each pass through a two-flop synchronizer, reset to 0. rq/aq are the synchronized versions, which adds 2 cycles of latency per edge.
- Undefined: rq/aq are the raw inputs, which must already be synchronous to clk. Latency is as stated in Behaviour.
- d_i and s_i are never synchronized. They are bundled data, stable while r_i is high.

Decomposition:
- Package split2_pkg contains:
  - state enum: IDLE, LOAD, REQ, RTZ (2 bits);
  - localparam SYNC_STAGES = 2.
- Sub-module sync2: single-bit two-flop synchronizer with async active-low reset to 0. Instantiated three times when SPLIT2_SYNC_EN is defined.

Test Plan:
- Reset: rst=0 with r_i=1 and a0_o=1 → all outputs 0, busy=0. After release with r_i=0: outputs stay idle.
- Steer to output 0: d_i=0x1 (N=1), s_i=0, raise r_i.
  - r0_o rises 2 cycles later (sync off), with d0_o=1 already valid the prior cycle; r1_o stays 0.
  - Ack a0_o → a_i=1, r0_o=0, cnt0=1.
  - Drop r_i and a0_o → a_i=0, busy=0.
- Steer to output 1 with N=8: d_i=0xA5, s_i=1 → r1_o=1, d1_o=0xA5, r0_o=0. Full handshake completes with cnt1=1, cnt0 unchanged.
- Stray ack: a0_o pulsed in IDLE and during a transfer to output 1 → no state change, no counter change.
- RTZ ordering: release r_i before a0_o falls → a_i stays 1 until both are low, then clears.
- Wrap and reset: CW=2, four transfers to output 0 → cnt0=0. Assert rst during REQ → r0_o=0, cnt0=0 immediately. Repeat with SPLIT2_SYNC_EN defined → request latency 4 cycles.

Source files
------------

// File: rtl/split2_sync_pkg.sv
// Shared types for the split2_sync steering block: FSM state encoding and synchronizer depth.
package split2_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, REQ, RTZ} state_t;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/split2_sync_if.sv
// Bundled-data channel group for split2_sync: one input channel, two steered output channels.
interface split2_sync_if #(parameter int N = 1);
    logic         r_i, a_i, s_i;
    logic [N-1:0] d_i;
    logic         r0_o, a0_o, r1_o, a1_o;
    logic [N-1:0] d0_o, d1_o;

    modport slave  (input  r_i, d_i, s_i, a0_o, a1_o,
                    output a_i, r0_o, d0_o, r1_o, d1_o);
    modport master (output r_i, d_i, s_i, a0_o, a1_o,
                    input  a_i, r0_o, d0_o, r1_o, d1_o);
endinterface

// File: rtl/split2_sync_sync2.sv
// Single-bit multi-flop synchronizer, async active-low reset to 0.
module sync2
    import split2_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ff <= '0;
        else      ff <= {ff[SYNC_STAGES-2:0], d};
    end

    assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/split2_sync.sv
// Clocked 4-phase split: steers each input token to output 0 or 1 by s_i.
// Define SPLIT2_SYNC_EN to pass r_i/a0_o/a1_o through two-flop synchronizers.
module split2_sync
    import split2_pkg::*;
#(
    parameter int N  = 1,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    split2_sync_if.slave  bus,
    output logic          busy,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);
    logic rq, aq0, aq1, aq_sel;

`ifdef SPLIT2_SYNC_EN
    sync2 u_sync_r  (.clk(clk), .rst(rst), .d(bus.r_i),  .q(rq));
    sync2 u_sync_a0 (.clk(clk), .rst(rst), .d(bus.a0_o), .q(aq0));
    sync2 u_sync_a1 (.clk(clk), .rst(rst), .d(bus.a1_o), .q(aq1));
`else
    assign rq  = bus.r_i;
    assign aq0 = bus.a0_o;
    assign aq1 = bus.a1_o;
`endif

    state_t        state, nxt;
    logic [N-1:0]  d_q, d_n;
    logic          sel_q, sel_n;
    logic          r0_q, r0_n, r1_q, r1_n, ai_q, ai_n;
    logic [CW-1:0] c0_n, c1_n;

    // Only the selected output's ack is ever looked at.
    assign aq_sel = sel_q ? aq1 : aq0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            d_q   <= '0;
            sel_q <= 1'b0;
            r0_q  <= 1'b0;
            r1_q  <= 1'b0;
            ai_q  <= 1'b0;
            cnt0  <= '0;
            cnt1  <= '0;
        end else begin
            state <= nxt;
            d_q   <= d_n;
            sel_q <= sel_n;
            r0_q  <= r0_n;
            r1_q  <= r1_n;
            ai_q  <= ai_n;
            cnt0  <= c0_n;
            cnt1  <= c1_n;
        end
    end

    always_comb begin
        nxt   = state;
        d_n   = d_q;
        sel_n = sel_q;
        r0_n  = r0_q;
        r1_n  = r1_q;
        ai_n  = ai_q;
        c0_n  = cnt0;
        c1_n  = cnt1;
        case (state)
            IDLE: if (rq) begin
                nxt   = LOAD;
                d_n   = bus.d_i;
                sel_n = bus.s_i;
            end
            // Data already drives both outputs; request rises one cycle later.
            LOAD: begin
                nxt  = REQ;
                r0_n = !sel_q;
                r1_n = sel_q;
            end
            REQ: if (aq_sel) begin
                nxt  = RTZ;
                r0_n = 1'b0;
                r1_n = 1'b0;
                ai_n = 1'b1;
                if (sel_q) c1_n = cnt1 + 1'b1;
                else       c0_n = cnt0 + 1'b1;
            end
            RTZ: if (!rq && !aq_sel) begin
                nxt  = IDLE;
                ai_n = 1'b0;
            end
            default: nxt = IDLE;
        endcase
    end

    assign bus.a_i  = ai_q;
    assign bus.r0_o = r0_q;
    assign bus.r1_o = r1_q;
    assign bus.d0_o = d_q;
    assign bus.d1_o = d_q;
    assign busy     = (state != IDLE);
endmodule

// File: tb/tb_split2_sync.sv
// Directed bench for split2_sync (N=8, CW=2); table-driven handshake plus wrap/latency/reset sequences.
module tb_split2_sync;
    localparam int N  = 8;
    localparam int CW = 2;
`ifdef SPLIT2_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT = 2 + EXTRA;

    logic          clk = 1'b0;
    logic          rst;
    logic          busy;
    logic [CW-1:0] cnt0, cnt1;
    int            tests = 0;
    int            fails = 0;

    split2_sync_if #(.N(N)) bus ();

    split2_sync #(.N(N), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .busy(busy),
        .cnt0(cnt0),
        .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         r, a0, a1, s;
        logic [7:0]   d;
        logic         er0, er1, eai, ebusy;
        logic [7:0]   ed;
        logic [1:0]   ec0, ec1;
    } vec_t;

    function automatic vec_t mk(logic r, logic a0, logic a1, logic s, logic [7:0] d,
                                logic er0, logic er1, logic eai, logic ebusy,
                                logic [7:0] ed, logic [1:0] ec0, logic [1:0] ec1);
        vec_t v;
        v.r = r; v.a0 = a0; v.a1 = a1; v.s = s; v.d = d;
        v.er0 = er0; v.er1 = er1; v.eai = eai; v.ebusy = ebusy;
        v.ed = ed; v.ec0 = ec0; v.ec1 = ec1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(string tag);
        chk({tag, " r0"},   32'(bus.r0_o), 0);
        chk({tag, " r1"},   32'(bus.r1_o), 0);
        chk({tag, " ai"},   32'(bus.a_i),  0);
        chk({tag, " busy"}, 32'(busy),     0);
    endtask

    task automatic do_xfer(logic sel, logic [7:0] d);
        int n;
        bus.d_i = d; bus.s_i = sel; bus.r_i = 1'b1;
        n = 0;
        while (!(sel ? bus.r1_o : bus.r0_o) && n < 20) begin tick(); n++; end
        chk("xfer req timeout", 32'(n < 20), 1);
        if (sel) bus.a1_o = 1'b1; else bus.a0_o = 1'b1;
        n = 0;
        while (!bus.a_i && n < 20) begin tick(); n++; end
        chk("xfer ack timeout", 32'(n < 20), 1);
        bus.r_i = 1'b0; bus.a0_o = 1'b0; bus.a1_o = 1'b0;
        n = 0;
        while (busy && n < 20) begin tick(); n++; end
        chk("xfer rtz timeout", 32'(n < 20), 1);
    endtask

    vec_t vt[16];

    initial begin
        int n;
        //           r  a0 a1 s  d      r0 r1 ai bz ed     c0 c1
        vt[0]  = mk(1, 0, 0, 0, 8'h01, 0, 0, 0, 1, 8'h01, 0, 0);
        vt[1]  = mk(1, 0, 0, 0, 8'h01, 1, 0, 0, 1, 8'h01, 0, 0);
        vt[2]  = mk(1, 1, 0, 0, 8'h01, 0, 0, 1, 1, 8'h01, 1, 0);
        vt[3]  = mk(0, 0, 0, 0, 8'h01, 0, 0, 0, 0, 8'h01, 1, 0);
        vt[4]  = mk(1, 0, 0, 1, 8'hA5, 0, 0, 0, 1, 8'hA5, 1, 0);
        vt[5]  = mk(1, 1, 0, 0, 8'h00, 0, 1, 0, 1, 8'hA5, 1, 0);
        vt[6]  = mk(1, 1, 0, 0, 8'h00, 0, 1, 0, 1, 8'hA5, 1, 0);
        vt[7]  = mk(1, 0, 1, 0, 8'h00, 0, 0, 1, 1, 8'hA5, 1, 1);
        vt[8]  = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'hA5, 1, 1);
        vt[9]  = mk(0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 8'hA5, 1, 1);
        vt[10] = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'hA5, 1, 1);
        vt[11] = mk(1, 0, 0, 0, 8'h3C, 0, 0, 0, 1, 8'h3C, 1, 1);
        vt[12] = mk(1, 0, 0, 0, 8'h3C, 1, 0, 0, 1, 8'h3C, 1, 1);
        vt[13] = mk(1, 1, 0, 0, 8'h3C, 0, 0, 1, 1, 8'h3C, 2, 1);
        vt[14] = mk(0, 1, 0, 0, 8'h3C, 0, 0, 1, 1, 8'h3C, 2, 1);
        vt[15] = mk(0, 0, 0, 0, 8'h3C, 0, 0, 0, 0, 8'h3C, 2, 1);

        // Reset held with live request/ack on the inputs.
        rst = 1'b0;
        bus.r_i = 1'b1; bus.a0_o = 1'b1; bus.a1_o = 1'b0; bus.s_i = 1'b0; bus.d_i = 8'hFF;
        repeat (3) tick();
        chk_idle("rst");
        chk("rst d0", 32'(bus.d0_o), 0);
        chk("rst d1", 32'(bus.d1_o), 0);
        chk("rst cnt0", 32'(cnt0), 0);
        chk("rst cnt1", 32'(cnt1), 0);
        bus.r_i = 1'b0; bus.a0_o = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        chk_idle("post-rst");

        for (int i = 0; i < 16; i++) begin
            bus.r_i = vt[i].r; bus.a0_o = vt[i].a0; bus.a1_o = vt[i].a1;
            bus.s_i = vt[i].s; bus.d_i = vt[i].d;
            repeat (1 + EXTRA) tick();
            chk($sformatf("v%0d r0", i),   32'(bus.r0_o), 32'(vt[i].er0));
            chk($sformatf("v%0d r1", i),   32'(bus.r1_o), 32'(vt[i].er1));
            chk($sformatf("v%0d ai", i),   32'(bus.a_i),  32'(vt[i].eai));
            chk($sformatf("v%0d busy", i), 32'(busy),     32'(vt[i].ebusy));
            chk($sformatf("v%0d d0", i),   32'(bus.d0_o), 32'(vt[i].ed));
            chk($sformatf("v%0d d1", i),   32'(bus.d1_o), 32'(vt[i].ed));
            chk($sformatf("v%0d cnt0", i), 32'(cnt0),     32'(vt[i].ec0));
            chk($sformatf("v%0d cnt1", i), 32'(cnt1),     32'(vt[i].ec1));
        end

        // Counter wrap: 2 -> 3 -> 0 on output 0, output 1 untouched.
        do_xfer(1'b0, 8'h11);
        chk("wrap cnt0 3", 32'(cnt0), 3);
        do_xfer(1'b0, 8'h22);
        chk("wrap cnt0 0", 32'(cnt0), 0);
        chk("wrap cnt1", 32'(cnt1), 1);
        do_xfer(1'b0, 8'h33);
        chk("cnt0 after wrap", 32'(cnt0), 1);

        // Request latency, then reset asserted mid-cycle while in REQ.
        bus.d_i = 8'h44; bus.s_i = 1'b0; bus.r_i = 1'b1;
        n = 0;
        while (!bus.r0_o && n < 20) begin tick(); n++; end
        chk("req latency", 32'(n), 32'(LAT));
        chk("req d0", 32'(bus.d0_o), 32'h44);
        chk("req r1 low", 32'(bus.r1_o), 0);
        #3 rst = 1'b0;
        #1;
        chk_idle("mid-rst");
        chk("mid-rst cnt0", 32'(cnt0), 0);
        chk("mid-rst cnt1", 32'(cnt1), 0);
        chk("mid-rst d0", 32'(bus.d0_o), 0);
        bus.r_i = 1'b0;
        tick();
        rst = 1'b1;
        repeat (4) tick();
        chk_idle("recover");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
